// File: rtl/spi_master_tx.sv
// SPI mode-0 initiator: byte-framed, MSB first, full duplex.
// _CS stays low across bytes until a byte tagged Last completes.
`timescale 1ns/1ps
module spi_master_tx #(
   parameter int DATA_WIDTH  = 8,
   parameter int HALF_PERIOD = 4,
   parameter int CS_GAP      = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  Start,
   input  logic [DATA_WIDTH-1:0] TxData,
   input  logic                  Last,
   output logic                  TxAccept,
   output logic [DATA_WIDTH-1:0] RxData,
   output logic                  RxValid,
   output logic                  Busy,
   output logic                  SCK,
   output logic                  MOSI,
   input  logic                  MISO,
   output logic                  _CS
);

   localparam int CNT_MAX = (HALF_PERIOD > CS_GAP) ?
                            HALF_PERIOD : CS_GAP;
   localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int BIT_W = $clog2(DATA_WIDTH + 1);

   localparam logic [CNT_W-1:0] HP_LAST =
      CNT_W'(HALF_PERIOD - 1);
   localparam logic [CNT_W-1:0] GAP_LAST =
      (CS_GAP > 0) ? CNT_W'(CS_GAP - 1) : '0;
   localparam logic [BIT_W-1:0] BITS_ALL = BIT_W'(DATA_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_SCK_HI,
      S_SCK_LO,
      S_WAIT_NEXT,
      S_TAIL,
      S_GAP
   } state_t;

   state_t                r_state, w_state;
   logic [CNT_W-1:0]      r_cnt, w_cnt;
   logic [BIT_W-1:0]      r_bits, w_bits;
   logic [DATA_WIDTH-1:0] r_shift_tx, w_shift_tx;
   logic [DATA_WIDTH-1:0] r_shift_rx, w_shift_rx;
   logic [DATA_WIDTH-1:0] r_rx_data, w_rx_data;
   logic                  r_last, w_last;
   logic                  r_tx_accept, w_tx_accept;
   logic                  r_rx_valid, w_rx_valid;
   logic                  r_busy, w_busy;
   logic                  r_sck, w_sck;
   logic                  r_mosi, w_mosi;
   logic                  r_cs_n, w_cs_n;
   logic                  w_hp_done;
   logic                  w_gap_done;

   assign w_hp_done  = (r_cnt == HP_LAST);
   assign w_gap_done = (r_cnt == GAP_LAST);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_bits      <= '0;
         r_shift_tx  <= '0;
         r_shift_rx  <= '0;
         r_rx_data   <= '0;
         r_last      <= 1'b0;
         r_tx_accept <= 1'b0;
         r_rx_valid  <= 1'b0;
         r_busy      <= 1'b0;
         r_sck       <= 1'b0;
         r_mosi      <= 1'b0;
         r_cs_n      <= 1'b1;
      end else begin
         r_state     <= w_state;
         r_cnt       <= w_cnt;
         r_bits      <= w_bits;
         r_shift_tx  <= w_shift_tx;
         r_shift_rx  <= w_shift_rx;
         r_rx_data   <= w_rx_data;
         r_last      <= w_last;
         r_tx_accept <= w_tx_accept;
         r_rx_valid  <= w_rx_valid;
         r_busy      <= w_busy;
         r_sck       <= w_sck;
         r_mosi      <= w_mosi;
         r_cs_n      <= w_cs_n;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_cnt       = r_cnt;
      w_bits      = r_bits;
      w_shift_tx  = r_shift_tx;
      w_shift_rx  = r_shift_rx;
      w_rx_data   = r_rx_data;
      w_last      = r_last;
      w_tx_accept = 1'b0;
      w_rx_valid  = 1'b0;
      w_busy      = r_busy;
      w_sck       = r_sck;
      w_mosi      = r_mosi;
      w_cs_n      = r_cs_n;
      case (r_state)
         S_IDLE, S_WAIT_NEXT: begin
            if (Start) begin
               w_shift_tx  = TxData;
               w_last      = Last;
               w_tx_accept = 1'b1;
               w_busy      = 1'b1;
               w_cs_n      = 1'b0;
               w_mosi      = TxData[DATA_WIDTH-1];
               w_bits      = '0;
               w_cnt       = '0;
               w_state     = S_LEAD;
            end
         end
         // Both enter a rising SCK edge and sample MISO there.
         S_LEAD, S_SCK_LO: begin
            if (w_hp_done) begin
               w_cnt      = '0;
               w_sck      = 1'b1;
               w_shift_rx = {r_shift_rx[DATA_WIDTH-2:0], MISO};
               w_bits     = r_bits + BIT_W'(1);
               w_state    = S_SCK_HI;
            end else begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end
         S_SCK_HI: begin
            if (w_hp_done) begin
               w_cnt = '0;
               w_sck = 1'b0;
               if (r_bits != BITS_ALL) begin
                  w_mosi     = r_shift_tx[DATA_WIDTH-2];
                  w_shift_tx = r_shift_tx << 1;
                  w_state    = S_SCK_LO;
               end else begin
                  w_rx_data  = r_shift_rx;
                  w_rx_valid = 1'b1;
                  w_state    = r_last ? S_TAIL : S_WAIT_NEXT;
               end
            end else begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end
         S_TAIL: begin
            if (w_hp_done) begin
               w_cnt  = '0;
               w_cs_n = 1'b1;
               w_mosi = 1'b0;
               if (CS_GAP == 0) begin
                  w_busy  = 1'b0;
                  w_state = S_IDLE;
               end else begin
                  w_state = S_GAP;
               end
            end else begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end
         S_GAP: begin
            if (w_gap_done) begin
               w_cnt   = '0;
               w_busy  = 1'b0;
               w_state = S_IDLE;
            end else begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   assign TxAccept = r_tx_accept;
   assign RxData   = r_rx_data;
   assign RxValid  = r_rx_valid;
   assign Busy     = r_busy;
   assign SCK      = r_sck;
   assign MOSI     = r_mosi;
   assign _CS      = r_cs_n;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: default instance plus a H=1, CS_GAP=0
// instance with MISO looped back to MOSI.
`timescale 1ns/1ps
module tb_spi_master_tx;

   localparam int W  = 8;
   localparam int H0 = 4;
   localparam int G0 = 2;
   localparam int H1 = 1;
   localparam int G1 = 0;

   typedef struct packed {
      logic       txacc;
      logic       rxv;
      logic       busy;
      logic       sck;
      logic       mosi;
      logic       csn;
      logic [7:0] rxd;
   } obs_t;

   typedef struct {
      int         c;
      logic [7:0] tx;
      logic       last;
      logic [7:0] miso;
      logic [7:0] exp_rx;
      int         ign1;
      int         ign2;
   } vec_t;

   logic CLK = 1'b0;
   logic RST;

   logic       a_start, a_last, a_miso;
   logic [7:0] a_tx;
   logic       a_txacc, a_rxv, a_busy, a_sck, a_mosi, a_csn;
   logic [7:0] a_rxd;

   logic       b_start, b_last, b_miso;
   logic [7:0] b_tx;
   logic       b_txacc, b_rxv, b_busy, b_sck, b_mosi, b_csn;
   logic [7:0] b_rxd;

   int checks   = 0;
   int failures = 0;
   int viol     = 0;
   int a_pulses = 0;
   int b_pulses = 0;

   logic [7:0] prev_rx [2];
   logic       in_wait [2];
   logic       last_bit [2];

   logic pa_sck, pa_csn, pa_mosi;
   logic pb_sck, pb_csn, pb_mosi;

   always #5 CLK = ~CLK;

   assign b_miso = b_mosi;

   spi_master_tx #(
      .DATA_WIDTH(W), .HALF_PERIOD(H0), .CS_GAP(G0)
   ) dut_a (
      .CLK(CLK), .RST(RST), .Start(a_start), .TxData(a_tx),
      .Last(a_last), .TxAccept(a_txacc), .RxData(a_rxd),
      .RxValid(a_rxv), .Busy(a_busy), .SCK(a_sck),
      .MOSI(a_mosi), .MISO(a_miso), ._CS(a_csn)
   );

   spi_master_tx #(
      .DATA_WIDTH(W), .HALF_PERIOD(H1), .CS_GAP(G1)
   ) dut_b (
      .CLK(CLK), .RST(RST), .Start(b_start), .TxData(b_tx),
      .Last(b_last), .TxAccept(b_txacc), .RxData(b_rxd),
      .RxValid(b_rxv), .Busy(b_busy), .SCK(b_sck),
      .MOSI(b_mosi), .MISO(b_miso), ._CS(b_csn)
   );

   always @(posedge a_sck) a_pulses++;
   always @(posedge b_sck) b_pulses++;

   // SCK must not move with _CS high; MOSI must not move with SCK high.
   always @(negedge CLK) begin
      if (a_csn && pa_csn && a_sck != pa_sck) viol++;
      if (a_mosi != pa_mosi && a_sck) viol++;
      if (b_csn && pb_csn && b_sck != pb_sck) viol++;
      if (b_mosi != pb_mosi && b_sck) viol++;
      pa_sck = a_sck; pa_csn = a_csn; pa_mosi = a_mosi;
      pb_sck = b_sck; pb_csn = b_csn; pb_mosi = b_mosi;
   end

   function automatic obs_t mk_obs(
      logic txacc, logic rxv, logic busy, logic sck,
      logic mosi, logic csn, logic [7:0] rxd);
      obs_t o;
      o.txacc = txacc; o.rxv = rxv; o.busy = busy;
      o.sck = sck; o.mosi = mosi; o.csn = csn; o.rxd = rxd;
      return o;
   endfunction

   function automatic obs_t get_obs(int c);
      if (c == 0)
         return mk_obs(a_txacc, a_rxv, a_busy, a_sck,
                       a_mosi, a_csn, a_rxd);
      return mk_obs(b_txacc, b_rxv, b_busy, b_sck,
                    b_mosi, b_csn, b_rxd);
   endfunction

   function automatic obs_t reset_obs();
      return mk_obs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
   endfunction

   // Expected outputs t edges after the accepting edge, from the
   // edge-timing rules: rises at (2k+1)h, final fall at 2Wh.
   function automatic obs_t exp_obs(
      int h, int g, int t, logic [7:0] tx, logic last,
      logic [7:0] rx, logic [7:0] prx);
      obs_t e;
      int   fin;
      fin     = 2 * W * h;
      e.txacc = (t == 0);
      e.rxv   = (t == fin);
      e.sck   = (t >= h) && (t < fin) && ((t / h) % 2 == 1);
      if (t < fin)
         e.mosi = tx[W - 1 - t / (2 * h)];
      else if (!last || t < fin + h)
         e.mosi = tx[0];
      else
         e.mosi = 1'b0;
      e.csn  = last && (t >= fin + h);
      e.busy = !last || (t < fin + h + g);
      e.rxd  = (t >= fin) ? rx : prx;
      return e;
   endfunction

   task automatic chk_obs(string nm, int c, int t,
                          obs_t act, obs_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s c=%0d t=%0d act=%b/%h exp=%b/%h",
                  nm, c, t, act[13:8], act.rxd,
                  exp[13:8], exp.rxd);
      end
   endtask

   task automatic chk_int(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
      end
   endtask

   task automatic set_in(int c, logic s, logic [7:0] d, logic l);
      if (c == 0) begin
         a_start = s; a_tx = d; a_last = l;
      end else begin
         b_start = s; b_tx = d; b_last = l;
      end
   endtask

   task automatic set_start(int c, logic s);
      if (c == 0) a_start = s;
      else b_start = s;
   endtask

   task automatic wait_cycles(int c, int n);
      obs_t e;
      for (int i = 0; i < n; i++) begin
         @(posedge CLK); #1;
         e = mk_obs(1'b0, 1'b0, in_wait[c], 1'b0,
                    in_wait[c] ? last_bit[c] : 1'b0,
                    !in_wait[c], prev_rx[c]);
         chk_obs("wait", c, i, get_obs(c), e);
      end
   endtask

   task automatic xfer(int c, logic [7:0] tx, logic last,
                       logic [7:0] miso, logic [7:0] exp_rx,
                       int ign1, int ign2, int abort_t,
                       logic hold);
      int   h, g, fin, tend, k, p0;
      obs_t e;
      h    = (c != 0) ? H1 : H0;
      g    = (c != 0) ? G1 : G0;
      fin  = 2 * W * h;
      tend = last ? fin + h + g : fin;
      p0   = (c != 0) ? b_pulses : a_pulses;
      set_in(c, 1'b1, tx, last);
      if (c == 0) a_miso = miso[W-1];
      for (int t = 0; t <= tend; t++) begin
         @(posedge CLK); #1;
         if (abort_t >= 0 && t == abort_t) begin
            chk_obs("abort", c, t, get_obs(c), reset_obs());
            RST = 1'b0;
            set_start(c, 1'b0);
            prev_rx[0] = '0; prev_rx[1] = '0;
            in_wait[0] = 1'b0; in_wait[1] = 1'b0;
            return;
         end
         e = exp_obs(h, g, t, tx, last, exp_rx, prev_rx[c]);
         chk_obs("xfer", c, t, get_obs(c), e);
         k = (t + h) / (2 * h);
         if (c == 0) a_miso = (k < W) ? miso[W-1-k] : 1'b0;
         if (t == ign1 || t == ign2)
            set_in(c, 1'b1, 8'($urandom), ~last);
         else if (!hold)
            set_start(c, 1'b0);
         if (abort_t >= 0 && t == abort_t - 1) begin
            RST = 1'b1;
            set_start(c, 1'b1);
         end
      end
      chk_int("pulses",
              ((c != 0) ? b_pulses : a_pulses) - p0, W);
      prev_rx[c]  = exp_rx;
      in_wait[c]  = !last;
      last_bit[c] = tx[0];
   endtask

   vec_t vecs [6];

   initial begin
      vecs[0] = '{0, 8'hA5, 1'b1, 8'h3C, 8'h3C, -1, -1};
      vecs[1] = '{0, 8'h00, 1'b1, 8'hFF, 8'hFF, -1, -1};
      vecs[2] = '{0, 8'hFF, 1'b1, 8'h00, 8'h00, -1, -1};
      vecs[3] = '{0, 8'h5A, 1'b1, 8'h96, 8'h96, 6, 68};
      vecs[4] = '{1, 8'h81, 1'b1, 8'h00, 8'h81, -1, -1};
      vecs[5] = '{1, 8'h7E, 1'b1, 8'h00, 8'h7E, 3, 16};

      for (int i = 0; i < 2; i++) begin
         prev_rx[i] = '0; in_wait[i] = 1'b0; last_bit[i] = 1'b0;
      end
      a_miso = 1'b0;
      RST = 1'b1;
      set_in(0, 1'b1, 8'hAA, 1'b1);
      set_in(1, 1'b1, 8'h55, 1'b1);
      repeat (3) @(posedge CLK);
      #1;
      chk_obs("reset", 0, 0, get_obs(0), reset_obs());
      chk_obs("reset", 1, 0, get_obs(1), reset_obs());
      RST = 1'b0;
      set_start(0, 1'b0);
      set_start(1, 1'b0);
      wait_cycles(0, 2);
      wait_cycles(1, 2);

      for (int i = 0; i < 6; i++) begin
         xfer(vecs[i].c, vecs[i].tx, vecs[i].last, vecs[i].miso,
              vecs[i].exp_rx, vecs[i].ign1, vecs[i].ign2, -1, 1'b0);
         wait_cycles(vecs[i].c, 2);
      end

      // Two-byte burst with the second byte offered late.
      xfer(0, 8'h12, 1'b0, 8'hF0, 8'hF0, -1, -1, -1, 1'b0);
      wait_cycles(0, 9);
      xfer(0, 8'h34, 1'b1, 8'h0F, 8'h0F, -1, -1, -1, 1'b0);
      wait_cycles(0, 2);

      // Start held high re-accepts on the first IDLE edge.
      xfer(1, 8'h81, 1'b1, 8'h00, 8'h81, -1, -1, -1, 1'b1);
      xfer(1, 8'h3C, 1'b1, 8'h00, 8'h3C, -1, -1, -1, 1'b0);
      wait_cycles(1, 2);

      // Reset mid-byte, with Start asserted alongside RST.
      xfer(0, 8'hFF, 1'b1, 8'hC3, 8'hC3, -1, -1, 30, 1'b0);
      wait_cycles(0, 5);
      wait_cycles(1, 1);
      xfer(0, 8'hFF, 1'b1, 8'hC3, 8'hC3, -1, -1, -1, 1'b0);
      wait_cycles(0, 1);

      for (int i = 0; i < 40; i++) begin
         int         c, h, g, tend, i1;
         logic [7:0] tx, mi;
         logic       last;
         c    = int'($urandom_range(0, 1));
         h    = (c != 0) ? H1 : H0;
         g    = (c != 0) ? G1 : G0;
         tx   = 8'($urandom);
         mi   = 8'($urandom);
         last = ($urandom_range(0, 2) != 0);
         tend = last ? 2 * W * h + h + g : 2 * W * h;
         i1   = ($urandom_range(0, 1) != 0) ?
                int'($urandom_range(1, tend - 1)) : -1;
         xfer(c, tx, last, mi, (c != 0) ? tx : mi,
              i1, -1, -1, 1'b0);
         wait_cycles(c, int'($urandom_range(0, 4)));
      end
      for (int c = 0; c < 2; c++)
         if (in_wait[c])
            xfer(c, 8'h99, 1'b1, 8'h66,
                 (c != 0) ? 8'h99 : 8'h66, -1, -1, -1, 1'b0);

      chk_int("invariants", viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
